// File: rtl/apb_reg_bridge.sv
// APB3 slave front end for a word register file.
// Wait-state insertion, one-hot write strobe, read mux, error flagging.
module apb_reg_bridge #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_REGS-1:0]        wr_en,
  output logic [DATA_W-1:0]          wdata,
  input  logic [NUM_REGS*DATA_W-1:0] rd_bus,
  output logic [7:0]                 err_cnt
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-3:0] NR = (ADDR_W-2)'(NUM_REGS);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [ADDR_W-3:0] idx;
  logic [IW-1:0]     idx_s;
  logic              err_addr, err_ro, err;
  logic              rdy, done;
  logic [DATA_W-1:0] rd_arr [NUM_REGS];

  assign idx      = addr_q[ADDR_W-1:2];
  assign idx_s    = idx[IW-1:0];
  assign err_addr = (addr_q[1:0] != 2'b00) | (idx >= NR);
  assign err_ro   = wr_q & ~err_addr & RO_MASK[idx_s];
  assign err      = err_addr | err_ro;
  assign rdy      = (state_q == ST_ACC) & (cnt_q == 4'd0);
  assign done     = rdy & psel & penable;

  // Split the flat read bus into per-register words.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_arr[i] = rd_bus[i*DATA_W +: DATA_W];
    end
  end

  // Response outputs, all gated by the completion cycle.
  always_comb begin
    pready  = rdy;
    pslverr = done & err;
    wr_en   = '0;
    prdata  = '0;
    if (done & wr_q & ~err) begin
      wr_en = NUM_REGS'(1) << idx_s;
    end
    if (done & ~wr_q & ~err) begin
      prdata = rd_arr[idx_s];
    end
  end

  assign wdata   = wdata_q;
  assign err_cnt = err_cnt_q;

  // Setup/access sequencing, wait counter and error counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    err_cnt_d = err_cnt_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (psel & ~penable) begin
          state_d = ST_ACC;
          cnt_d   = 4'(WAIT_CYCLES);
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
        end
      end
      (state_q == ST_ACC): begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (done) begin
          state_d = ST_IDLE;
          if (err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Bench for apb_reg_bridge: three configurations, a transaction model
// checked every cycle, plus directed literal expectations.
module tb_apb_reg_bridge;

  localparam int WC [3] = '{0, 3, 2};
  localparam logic [7:0] RO [3] = '{8'h01, 8'h00, 8'h00};

  logic        pclk;
  logic        rst_n;
  logic        psel [3];
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [7:0]  wr_en [3];
  logic [31:0] wdata [3];
  logic [7:0]  err_cnt [3];
  logic [255:0] rd_bus;
  logic [31:0] cells [8];

  int n_cmp = 0;
  int n_bad = 0;

  apb_reg_bridge #(.WAIT_CYCLES(0), .RO_MASK(8'h01)) u0 (
    .pclk(pclk), .rst_n(rst_n), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .wr_en(wr_en[0]), .wdata(wdata[0]), .rd_bus(rd_bus),
    .err_cnt(err_cnt[0]));

  apb_reg_bridge #(.WAIT_CYCLES(3), .RO_MASK(8'h00)) u1 (
    .pclk(pclk), .rst_n(rst_n), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .wr_en(wr_en[1]), .wdata(wdata[1]), .rd_bus(rd_bus),
    .err_cnt(err_cnt[1]));

  apb_reg_bridge #(.WAIT_CYCLES(2), .RO_MASK(8'h00)) u2 (
    .pclk(pclk), .rst_n(rst_n), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]),
    .wr_en(wr_en[2]), .wdata(wdata[2]), .rd_bus(rd_bus),
    .err_cnt(err_cnt[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [31:0] cell_init(int i);
    return (i == 1) ? 32'h12345678 : (32'h0BAD0000 | 32'(i));
  endfunction

  // Register cells that capture wdata on any strobe.
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cells[i] <= cell_init(i);
    end else begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 8; i++)
          if (wr_en[k][i]) cells[i] <= wdata[k];
    end
  end

  always_comb begin
    rd_bus = '0;
    for (int i = 0; i < 8; i++) rd_bus[i*32 +: 32] = cells[i];
  end

  // Transaction model: latched request and access cycles elapsed.
  logic        m_act [3];
  int          m_el  [3];
  logic [11:0] m_addr [3];
  logic        m_wr  [3];
  logic [31:0] m_wd  [3];
  logic [7:0]  m_err [3];

  function automatic logic m_done(int k);
    return m_act[k] && (m_el[k] >= WC[k]) && psel[k] && penable;
  endfunction

  function automatic logic m_bad(int k);
    logic [9:0] ix;
    ix = m_addr[k][11:2];
    if (m_addr[k][1:0] != 2'b00) return 1'b1;
    if (ix >= 10'd8) return 1'b1;
    return m_wr[k] && RO[k][ix[2:0]];
  endfunction

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_act[k] <= 1'b0; m_el[k] <= 0; m_addr[k] <= '0;
        m_wr[k] <= 1'b0; m_wd[k] <= '0; m_err[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!m_act[k]) begin
          if (psel[k] && !penable) begin
            m_act[k] <= 1'b1; m_el[k] <= 0;
            m_addr[k] <= paddr; m_wr[k] <= pwrite; m_wd[k] <= pwdata;
          end
        end else if (!psel[k]) begin
          m_act[k] <= 1'b0;
        end else if (m_done(k)) begin
          m_act[k] <= 1'b0;
          if (m_bad(k) && m_err[k] != 8'd255) m_err[k] <= m_err[k] + 8'd1;
        end else begin
          m_el[k] <= m_el[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  initial begin
    forever begin
      @(negedge pclk);
      for (int k = 0; k < 3; k++) begin
        logic d, e;
        logic [2:0] ix;
        logic [7:0] ew;
        logic [31:0] ep;
        d  = m_done(k);
        e  = m_bad(k);
        ix = m_addr[k][4:2];
        ew = (d && m_wr[k] && !e) ? (8'd1 << ix) : 8'd0;
        ep = (d && !m_wr[k] && !e) ? cells[ix] : 32'd0;
        chk($sformatf("d%0d.pready", k), 32'(pready[k]),
            32'(m_act[k] && m_el[k] >= WC[k]));
        chk($sformatf("d%0d.pslverr", k), 32'(pslverr[k]), 32'(d && e));
        chk($sformatf("d%0d.wr_en", k), 32'(wr_en[k]), 32'(ew));
        chk($sformatf("d%0d.prdata", k), prdata[k], ep);
        chk($sformatf("d%0d.wdata", k), wdata[k], m_wd[k]);
        chk($sformatf("d%0d.err_cnt", k), 32'(err_cnt[k]), 32'(m_err[k]));
      end
    end
  end

  task automatic xfer(input int k, input logic wr, input logic [11:0] a,
                      input logic [31:0] d, output int ncyc,
                      output logic [31:0] rd, output logic er,
                      output logic [7:0] wseen, output int pulses,
                      output int early);
    logic fin;
    @(posedge pclk); #1;
    psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = 12'hFFC; pwdata = 32'h5555AAAA;
    ncyc = 0; rd = '0; er = 1'b0; wseen = '0; pulses = 0; early = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge pclk);
      ncyc++;
      if (wr_en[k] != 8'd0) begin
        pulses++; wseen = wseen | wr_en[k];
      end
      if (pready[k]) begin
        rd = prdata[k]; er = pslverr[k]; fin = 1'b1;
      end else begin
        if (prdata[k] != 32'd0) early++;
        if (ncyc > 40) begin
          chk("timeout", 32'd1, 32'd0); fin = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
  endtask

  int nc, pu, ea;
  logic [31:0] rd;
  logic er;
  logic [7:0] ws;

  initial begin
    for (int k = 0; k < 3; k++) psel[k] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge pclk);
    for (int k = 0; k < 3; k++) begin
      chk("rst.pready", 32'(pready[k]), 32'd0);
      chk("rst.wr_en", 32'(wr_en[k]), 32'd0);
      chk("rst.err_cnt", 32'(err_cnt[k]), 32'd0);
      chk("rst.wdata", wdata[k], 32'd0);
    end
    @(posedge pclk); #1 rst_n = 1'b1;

    xfer(0, 1'b1, 12'h008, 32'hDEADBEEF, nc, rd, er, ws, pu, ea);
    chk("w0.cycles", 32'(nc), 32'd1);
    chk("w0.wr_en", 32'(ws), 32'h04);
    chk("w0.pulses", 32'(pu), 32'd1);
    chk("w0.wdata", wdata[0], 32'hDEADBEEF);
    chk("w0.err", 32'(er), 32'd0);
    idle();
    chk("w0.cell", cells[2], 32'hDEADBEEF);

    xfer(1, 1'b0, 12'h004, 32'h0, nc, rd, er, ws, pu, ea);
    chk("r1.cycles", 32'(nc), 32'd4);
    chk("r1.early", 32'(ea), 32'd0);
    chk("r1.data", rd, 32'h12345678);
    chk("r1.err", 32'(er), 32'd0);
    idle();

    xfer(0, 1'b1, 12'h006, 32'h11, nc, rd, er, ws, pu, ea);
    chk("mis.err", 32'(er), 32'd1);
    chk("mis.wr_en", 32'(ws), 32'd0);
    idle();
    chk("mis.cnt", 32'(err_cnt[0]), 32'd1);
    xfer(0, 1'b0, 12'h020, 32'h0, nc, rd, er, ws, pu, ea);
    chk("oor.err", 32'(er), 32'd1);
    chk("oor.data", rd, 32'd0);
    idle();
    chk("oor.cnt", 32'(err_cnt[0]), 32'd2);
    xfer(0, 1'b1, 12'h000, 32'h1, nc, rd, er, ws, pu, ea);
    chk("ro.err", 32'(er), 32'd1);
    chk("ro.wr_en", 32'(ws), 32'd0);
    idle();
    chk("ro.cnt", 32'(err_cnt[0]), 32'd3);
    chk("ro.cell", cells[0], 32'h0BAD0000);
    xfer(0, 1'b0, 12'h000, 32'h0, nc, rd, er, ws, pu, ea);
    chk("ro.read", rd, 32'h0BAD0000);
    chk("ro.rderr", 32'(er), 32'd0);
    idle();

    @(posedge pclk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 12'h014; pwdata = 32'h77;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    chk("ab.pready", 32'(pready[2]), 32'd0);
    idle();
    idle();
    chk("ab.cell", cells[5], 32'h0BAD0005);
    chk("ab.cnt", 32'(err_cnt[2]), 32'd0);
    xfer(2, 1'b1, 12'h014, 32'h77, nc, rd, er, ws, pu, ea);
    chk("ab2.cycles", 32'(nc), 32'd3);
    chk("ab2.wr_en", 32'(ws), 32'h20);
    idle();
    chk("ab2.cell", cells[5], 32'h77);

    xfer(0, 1'b1, 12'h00C, 32'hA5, nc, rd, er, ws, pu, ea);
    chk("b2b.wr_en", 32'(ws), 32'h08);
    chk("b2b.pulses", 32'(pu), 32'd1);
    xfer(0, 1'b0, 12'h00C, 32'h0, nc, rd, er, ws, pu, ea);
    chk("b2b.read", rd, 32'h000000A5);
    chk("b2b.rdpulse", 32'(pu), 32'd0);
    idle();

    for (int i = 0; i < 260; i++)
      xfer(0, 1'b0, 12'h001, 32'h0, nc, rd, er, ws, pu, ea);
    idle();
    chk("sat.cnt", 32'(err_cnt[0]), 32'd255);

    xfer(0, 1'b1, 12'h010, 32'hCAFE, nc, rd, er, ws, pu, ea);
    chk("rst2.pre", 32'(ws), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2.wr_en", 32'(wr_en[0]), 32'd0);
    chk("rst2.pready", 32'(pready[0]), 32'd0);
    chk("rst2.pslverr", 32'(pslverr[0]), 32'd0);
    chk("rst2.prdata", prdata[0], 32'd0);
    chk("rst2.err_cnt", 32'(err_cnt[0]), 32'd0);
    chk("rst2.wdata", wdata[0], 32'd0);
    @(posedge pclk); #1;
    psel[0] = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 rst_n = 1'b1;
    xfer(0, 1'b0, 12'h010, 32'h0, nc, rd, er, ws, pu, ea);
    chk("rst2.read", rd, 32'h0BAD0004);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
- APB3 slave front end that sits directly upstream of the per-register storage cells in a peripheral register file.
- Tracks the APB setup/access phases and inserts a programmable number of wait states.
- Decodes the word address into a one-cycle, one-hot write strobe plus a shared write-data bus.
- Muxes the read-back values, and flags unmapped, misaligned or read-only-write accesses on pslverr.

Parameters:
- ADDR_W, 12, paddr width in bits.
- DATA_W, 32, data width in bits.
- NUM_REGS, 8, number of word registers, mapped at byte offsets 0, 4, ... 4*(NUM_REGS-1).
- WAIT_CYCLES, 0, wait states per transfer (0..15).
- RO_MASK, {NUM_REGS{1'b0}}, bit i = 1 marks register i as read-only.

Ports:
- pclk  in  1  APB clock.
- rst_n  in  1  reset, asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data, valid when pready=1 and the transfer is a read.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid with pready.
- wr_en  out  NUM_REGS  one-hot write strobe, one pclk wide.
- wdata  out  DATA_W  write data to the register cells.
- rd_bus  in  NUM_REGS*DATA_W  register values; register i occupies bits [i*DATA_W +: DATA_W].
- err_cnt  out  8  saturating count of error responses.

Behaviour:
- Reset: clock pclk; reset rst_n, asynchronous, active-low. During reset:
  - state=IDLE, wait counter=0.
  - Latched addr/dir/data = 0.
  - err_cnt=0, wdata=0.
  - pready, pslverr, prdata and wr_en are all 0.
- States: IDLE, ACCESS.
- IDLE:
  - pready=0.
  - On a clock edge with psel=1 and penable=0 (setup phase): latch paddr, pwrite and pwdata; load cnt=WAIT_CYCLES; go to ACCESS.
  - psel=1 with penable=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS:
  - pready = (cnt==0), combinational from registered state.
  - While cnt!=0 and psel=1, cnt decrements each edge.
  - Completion is a cycle with psel=1, penable=1 and pready=1. On the following edge return to IDLE.
  - Zero wait states: pready=1 in the first access cycle. Total transfer = 2 cycles; with N wait states = 2+N cycles.
- Abort: psel=0 while in ACCESS → return to IDLE next edge, no strobe, err_cnt unchanged.
- Decode (uses latched values):
  - idx = addr[ADDR_W-1:2].
  - err_addr = (addr[1:0]!=0) or (idx>=NUM_REGS).
  - err_ro = write and RO_MASK[idx] (only when err_addr=0).
- pslverr = completion cycle and (err_addr or err_ro); it is 0 at all other times.
- wr_en[idx] = completion cycle and write and !err_addr and !err_ro. It is exactly one cycle wide, so the register cell captures wdata on the same edge that ends the transfer.
- wdata = latched pwdata, held stable from the first access cycle until the next setup.
- prdata:
  - = rd_bus slice idx in a read completion cycle with no error.
  - = 0 in every other cycle, including error responses and writes.
- err_cnt: +1 on each edge that ends an error completion; saturates at 255 and does not wrap.
- pwdata/paddr changes during ACCESS have no effect; the latched copies are used.
- Back-to-back transfers: a setup may immediately follow completion. There is no idle cycle requirement beyond the APB setup phase.
- Reset asserted mid-transfer: immediate return to reset values; wr_en drops asynchronously with no partial write.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x008 → pready=1 in the 2nd cycle; wr_en=8'b0000_0100 for exactly 1 cycle; wdata=0xDEADBEEF; pslverr=0.
- WAIT_CYCLES=3: read 0x004 with rd_bus slice 1=0x12345678 → pready low for 3 access cycles, high on the 4th; prdata=0x12345678 only in that cycle.
- Error cases, each giving pslverr=1 with pready, wr_en=0, prdata=0 and err_cnt incremented:
  - Misaligned write to 0x006.
  - Out-of-range read of 0x020 (NUM_REGS=8).
  - RO_MASK=8'h01, write to 0x000.
- Abort: WAIT_CYCLES=2; drop psel after 1 access cycle → state returns to IDLE; no wr_en pulse; err_cnt unchanged; the next transfer completes normally.
- 260 consecutive error transfers → err_cnt=255 and held; then assert rst_n=0 mid-transfer → all outputs 0 immediately, err_cnt=0.
- Back-to-back: write 0xA5 to 0x00C, then read 0x00C on the next setup with the register cell echoing it → one wr_en pulse to reg 3; read returns 0x000000A5.
